// File: rtl/ysyx_pc_redirect.sv
// Commit-side PC redirect unit: buffers commit events, confirms predictions,
// and runs an IFU flush handshake before redirecting the PC on a mispredict.
module ysyx_pc_redirect #(
  parameter int               DATA_W    = 32,
  parameter int               DEPTH     = 2,
  parameter int               FLUSH_MAX = 15,
  parameter logic [DATA_W-1:0] PC_INIT  = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmt_valid,
  output logic              cmt_ready,
  input  logic              cmt_is_branch,
  input  logic [DATA_W-1:0] cmt_npc_pred,
  input  logic [DATA_W-1:0] cmt_npc_actual,
  input  logic              ifu_flush_ack,
  output logic              good_speculation,
  output logic [DATA_W-1:0] pc_ifu,
  output logic              bad_speculation,
  output logic              branch_change,
  output logic              branch_retire,
  output logic [DATA_W-1:0] npc_wdata,
  output logic              flush_timeout
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FLUSH_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIR
  } state_e;

  state_e            state_q;
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic [FCW-1:0]    fcnt_q;
  logic [DATA_W-1:0] tgt_q, pc_q, npc_q;
  logic              good_q, ret_q, chg_q, bad_q, tmo_q;

  logic              br_q   [DEPTH];
  logic [DATA_W-1:0] pred_q [DEPTH];
  logic [DATA_W-1:0] act_q  [DEPTH];

  logic push, pop, mis, ack_hit, tmo_hit;

  assign cmt_ready = (state_q == S_IDLE) && (cnt_q < CW'(DEPTH));
  assign push      = cmt_valid & cmt_ready;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);
  assign mis       = pop && (act_q[rd_q] != pred_q[rd_q]);
  assign ack_hit   = ifu_flush_ack;
  assign tmo_hit   = (fcnt_q == FCW'(FLUSH_MAX));

  always_ff @(posedge clk) begin
    if (push) begin
      br_q[wr_q]   <= cmt_is_branch;
      pred_q[wr_q] <= cmt_npc_pred;
      act_q[wr_q]  <= cmt_npc_actual;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      tgt_q   <= PC_INIT;
      pc_q    <= PC_INIT;
      npc_q   <= PC_INIT;
      good_q  <= 1'b0;
      ret_q   <= 1'b0;
      chg_q   <= 1'b0;
      bad_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      good_q <= 1'b0;
      ret_q  <= 1'b0;
      chg_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // younger entries and a same-cycle push are wrong-path
          if (mis) begin
            tgt_q   <= act_q[rd_q];
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            bad_q   <= 1'b1;
            state_q <= S_FLUSH;
          end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) begin
              rd_q   <= rd_q + AW'(1);
              good_q <= 1'b1;
              pc_q   <= act_q[rd_q];
              ret_q  <= br_q[rd_q];
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
          end
        end
        S_FLUSH: begin
          if (ack_hit || tmo_hit) begin
            if (!ack_hit) tmo_q <= 1'b1;
            bad_q   <= 1'b0;
            chg_q   <= 1'b1;
            npc_q   <= tgt_q;
            state_q <= S_REDIR;
          end else begin
            fcnt_q <= tmo_hit ? fcnt_q : fcnt_q + FCW'(1);
          end
        end
        S_REDIR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign good_speculation = good_q;
  assign branch_retire    = ret_q;
  assign branch_change    = chg_q;
  assign bad_speculation  = bad_q;
  assign flush_timeout    = tmo_q;
  assign pc_ifu           = pc_q;
  assign npc_wdata        = npc_q;

endmodule

// File: tb/tb_ysyx_pc_redirect.sv
// Directed and random bench for ysyx_pc_redirect with a queue-based
// transaction model of commit, flush and redirect behaviour.
module tb_ysyx_pc_redirect;

  localparam int          DEPTH = 2;
  localparam int          FMAX  = 15;
  localparam logic [31:0] PINIT = 32'h8000_0000;

  logic        clk = 0;
  logic        rst = 1;
  logic        cmt_valid = 0;
  logic        cmt_ready;
  logic        cmt_is_branch = 0;
  logic [31:0] cmt_npc_pred = 0;
  logic [31:0] cmt_npc_actual = 0;
  logic        ifu_flush_ack = 0;
  logic        good_speculation;
  logic [31:0] pc_ifu;
  logic        bad_speculation;
  logic        branch_change;
  logic        branch_retire;
  logic [31:0] npc_wdata;
  logic        flush_timeout;

  ysyx_pc_redirect #(
    .DATA_W(32), .DEPTH(DEPTH), .FLUSH_MAX(FMAX), .PC_INIT(PINIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
    .cmt_is_branch(cmt_is_branch),
    .cmt_npc_pred(cmt_npc_pred), .cmt_npc_actual(cmt_npc_actual),
    .ifu_flush_ack(ifu_flush_ack),
    .good_speculation(good_speculation), .pc_ifu(pc_ifu),
    .bad_speculation(bad_speculation), .branch_change(branch_change),
    .branch_retire(branch_retire), .npc_wdata(npc_wdata),
    .flush_timeout(flush_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          br;
    logic [31:0] pred;
    logic [31:0] act;
  } ev_t;

  ev_t         q[$];
  bit          m_flush, m_redir;
  int          m_fc;
  logic [31:0] m_tgt;
  bit          e_good, e_ret, e_chg, e_bad, e_tmo;
  logic [31:0] e_pc, e_npc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_flush = 0; m_redir = 0; m_fc = 0; m_tgt = PINIT;
    e_good = 0; e_ret = 0; e_chg = 0; e_bad = 0; e_tmo = 0;
    e_pc = PINIT; e_npc = PINIT;
  endtask

  task automatic step(input bit r, input bit v, input bit br,
                      input logic [31:0] pr, input logic [31:0] ac,
                      input bit ak);
    bit  rdy;
    ev_t e;
    rst = r; cmt_valid = v; cmt_is_branch = br;
    cmt_npc_pred = pr; cmt_npc_actual = ac; ifu_flush_ack = ak;
    rdy = !m_flush && !m_redir && (q.size() < DEPTH);
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      e_good = 0; e_ret = 0; e_chg = 0;
      if (m_redir) begin
        m_redir = 0;
      end else if (m_flush) begin
        if (ak || m_fc == FMAX) begin
          if (!ak) e_tmo = 1;
          m_flush = 0; m_redir = 1;
          e_bad = 0; e_chg = 1; e_npc = m_tgt;
        end else begin
          m_fc++;
        end
      end else begin
        bit dropped = 0;
        if (q.size() > 0) begin
          e = q.pop_front();
          if (e.pred !== e.act) begin
            m_flush = 1; m_fc = 0; m_tgt = e.act; e_bad = 1;
            q.delete();
            dropped = 1;
          end else begin
            e_good = 1; e_pc = e.act; e_ret = e.br;
          end
        end
        if (v && rdy && !dropped) q.push_back('{br, pr, ac});
      end
    end
    #1;
    chk("cmt_ready", cmt_ready,
        32'(!m_flush && !m_redir && q.size() < DEPTH));
    chk("good_spec", good_speculation, 32'(e_good));
    chk("br_retire", branch_retire, 32'(e_ret));
    chk("br_change", branch_change, 32'(e_chg));
    chk("bad_spec", bad_speculation, 32'(e_bad));
    chk("timeout", flush_timeout, 32'(e_tmo));
    chk("pc_ifu", pc_ifu, e_pc);
    chk("npc_wdata", npc_wdata, e_npc);
  endtask

  task automatic idle(input bit ak);
    step(0, 0, 0, 0, 0, ak);
  endtask

  task automatic push(input bit br, input logic [31:0] pr,
                      input logic [31:0] ac);
    step(0, 1, br, pr, ac, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    m_reset();
    // reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // correct branch
    push(1, 32'h8000_0010, 32'h8000_0010);
    idle(0);
    chk("t2_pc", pc_ifu, 32'h8000_0010);
    idle(0);
    // mispredict, second event dropped, ack in 3rd FLUSH cycle
    push(1, 32'h8000_0004, 32'h8000_0100);
    push(0, 32'h8000_0200, 32'h8000_0200);
    idle(0);
    idle(0);
    idle(1);
    chk("t3_npc", npc_wdata, 32'h8000_0100);
    idle(0);
    idle(0);
    idle(0);
    // timeout with ack held low
    push(1, 32'h8000_0020, 32'h8000_0300);
    for (int i = 0; i < 22; i++) idle(0);
    chk("t4_sticky", flush_timeout, 32'd1);
    ifu_flush_ack = 1;
    idle(1);
    idle(0);
    chk("t4_still", flush_timeout, 32'd1);
    // ack and timeout coincide
    step(1, 0, 0, 0, 0, 0);
    push(0, 32'h8000_0030, 32'h8000_0400);
    idle(0);
    for (int i = 0; i < FMAX; i++) idle(0);
    idle(1);
    chk("t4_tie", flush_timeout, 32'd0);
    idle(0);
    idle(0);
    // back-to-back correct events
    for (int i = 0; i < 4; i++) begin
      a = 32'h8000_1000 + 32'(i * 4);
      push(i[0], a, a);
    end
    idle(0);
    idle(0);
    // reset during flush
    push(1, 32'h8000_0040, 32'h8000_0500);
    idle(0);
    idle(0);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle(1);
    // random
    for (int i = 0; i < 600; i++) begin
      a = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
      b = ($urandom_range(0, 5) == 0) ? (a + 32'h40) : a;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1), a, b,
           ($urandom_range(0, 4) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
